// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// updown_mod_counter
//
// Parametrised modulo up/down counter. It is the general timing/event counter
// that feeds uo_out or internal sequencers in the tile designs. It replaces the
// old free-running 8-bit counter.
//
// Parameters
//   WIDTH    : counter width in bits (2..16)
//   modulus  : parameter MOD, count runs 0..MOD-1 (2..2**WIDTH)
//   PRESCALE : enabled cycles per step when the prescaler is compiled in
//              (2..256). It is ignored otherwise.
//
// Optional feature
//   COUNTER_PRESCALER_EN : when defined, a step happens only once every
//                          PRESCALE enabled cycles. When undefined, every
//                          enabled cycle is a step.
//
// Ports
//   clk      in  1      clock, rising edge
//   rst      in  1      asynchronous active-high reset
//   en       in  1      count enable
//   up_dn    in  1      1 = count up, 0 = count down
//   sat_mode in  1      0 = wrap at bounds, 1 = saturate at bounds
//   clear    in  1      synchronous clear of count, prescaler and ovf
//   load     in  1      synchronous load of load_val (clamped to MOD-1)
//   load_val in  WIDTH  value to load
//   ovf_clr  in  1      clears the sticky ovf flag
//   count    out WIDTH  current count, registered
//   tc       out 1      terminal-count pulse on a wrap, registered
//   ovf      out 1      sticky overflow/underflow flag, registered
//
// Priority each cycle: clear > load > step > hold. Every output comes straight
// from a flop, so no output has a combinational path from an input.
// ---------------------------------------------------------------------------
module updown_mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MOD      = 256,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // The modulus can be as large as 2**WIDTH. For that reason, bound
  // comparisons and the +/-1 arithmetic are done one bit wider than the counter.
  localparam logic [WIDTH:0] TOP_X = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

  localparam bit CFG_OK = (WIDTH >= 2) && (WIDTH <= 16) &&
                          (MOD >= 2) && (MOD <= (1 << WIDTH)) &&
                          (PRESCALE >= 2) && (PRESCALE <= 256);

  // Catch an illegal parameter set in simulation. This block has no hardware.
  always_comb begin : cfg_check
    assert (CFG_OK);
  end

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Clamp an out-of-range load value to the top of the count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] v_x;
    v_x = {1'b0, v};
    if (v_x > TOP_X) begin
      return TOP_X[WIDTH-1:0];
    end
    return v;
  endfunction

  // Return 1 when a step in direction 'up' would cross a bound.
  function automatic logic at_bound(input logic [WIDTH:0] c, input logic up);
    if (up) begin
      return (c == TOP_X);
    end
    return (c == '0);
  endfunction

  // Return the count after one step. This covers the wrap and saturate cases.
  function automatic logic [WIDTH:0] step_val(input logic [WIDTH:0] c,
                                              input logic up,
                                              input logic sat);
    logic [WIDTH:0] r;
    if (up) begin
      if (c == TOP_X) begin
        r = sat ? c : '0;
      end else begin
        r = c + ONE_X;
      end
    end else begin
      if (c == '0) begin
        r = sat ? c : TOP_X;
      end else begin
        r = c - ONE_X;
      end
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Prescaler
  // -------------------------------------------------------------------------
  logic ps_done;

`ifdef COUNTER_PRESCALER_EN
  localparam int             PS_W    = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] ps_q;
  logic [PS_W-1:0] ps_d;

  assign ps_done = (ps_q == PS_LAST);

  // The prescaler counts enabled cycles only. Clear and load restart the
  // spacing, so the first step after either comes a full PRESCALE cycles later.
  always_comb begin
    ps_d = ps_q;
    if (clear || load) begin
      ps_d = '0;
    end else if (en) begin
      ps_d = ps_done ? '0 : ps_q + PS_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  assign ps_done = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   cnt_step_x;
  logic             step_go;
  logic             hit_bound;
  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic             ovf_d;

  assign cnt_x      = {1'b0, count};
  assign step_go    = en & ~clear & ~load & ps_done;
  assign hit_bound  = step_go & at_bound(cnt_x, up_dn);
  assign cnt_step_x = step_val(cnt_x, up_dn, sat_mode);

  always_comb begin
    count_d = count;
    tc_d    = 1'b0;
    ovf_d   = ovf;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = clamp_load(load_val);
      if (ovf_clr) begin
        ovf_d = 1'b0;
      end
    end else begin
      if (ovf_clr) begin
        ovf_d = 1'b0;
      end
      if (step_go) begin
        count_d = cnt_step_x[WIDTH-1:0];
      end
      // A boundary event in the same cycle as ovf_clr still sets ovf.
      // tc pulses only when the count actually wraps.
      if (hit_bound) begin
        ovf_d = 1'b1;
        tc_d  = ~sat_mode;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_d;
      tc    <= tc_d;
      ovf   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
module tb_updown_mod_counter;

`ifdef COUNTER_PRESCALER_EN
  localparam int PSN = 4;
`else
  localparam int PSN = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, en, up_dn, sat_mode, clear, load, ovf_clr;
  logic [7:0] lv8;
  logic [7:0] count8;
  logic [3:0] count10;
  logic       tc8, ovf8, tc10, ovf10;

  int nchk  = 0;
  int nfail = 0;

  // Reference model state: one set per instance.
  int m8c, m8ps, m10c, m10ps;
  bit m8t, m8o, m10t, m10o;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(8), .MOD(256), .PRESCALE(4)) u_d8 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .clear(clear), .load(load), .load_val(lv8), .ovf_clr(ovf_clr),
    .count(count8), .tc(tc8), .ovf(ovf8)
  );

  updown_mod_counter #(.WIDTH(4), .MOD(10), .PRESCALE(4)) u_d10 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .clear(clear), .load(load), .load_val(lv8[3:0]), .ovf_clr(ovf_clr),
    .count(count10), .tc(tc10), .ovf(ovf10)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: integer count, signed target, modulo fold-back.
  task automatic model_step(input int modv, input int lvv, inout int c,
                            inout bit t, inout bit o, inout int ps);
    int tgt;
    bit go;
    t = 0;
    if (rst) begin
      c = 0; o = 0; ps = 0;
    end else if (clear) begin
      c = 0; o = 0; ps = 0;
    end else if (load) begin
      c  = (lvv > modv - 1) ? modv - 1 : lvv;
      ps = 0;
      if (ovf_clr) o = 0;
    end else begin
      if (ovf_clr) o = 0;
      go = 0;
      if (en) begin
        ps = ps + 1;
        if (ps == PSN) begin
          ps = 0;
          go = 1;
        end
      end
      if (go) begin
        tgt = c + (up_dn ? 1 : -1);
        if (tgt < 0 || tgt >= modv) begin
          o = 1;
          if (!sat_mode) begin
            c = (tgt + modv) % modv;
            t = 1;
          end
        end else begin
          c = tgt;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("d8.count",  count8,  m8c);
    chk("d8.tc",     tc8,     m8t);
    chk("d8.ovf",    ovf8,    m8o);
    chk("d10.count", count10, m10c);
    chk("d10.tc",    tc10,    m10t);
    chk("d10.ovf",   ovf10,   m10o);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(256, int'(lv8),        m8c,  m8t,  m8o,  m8ps);
    model_step(10,  int'(lv8 & 8'hF), m10c, m10t, m10o, m10ps);
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    repeat (n * PSN) tick();
  endtask

  initial begin
    int tcs;
    rst = 1'b1; en = 0; up_dn = 1; sat_mode = 0; clear = 0; load = 0;
    ovf_clr = 0; lv8 = 0;
    m8c = 0; m8ps = 0; m10c = 0; m10ps = 0;
    m8t = 0; m8o = 0; m10t = 0; m10o = 0;

    // Reset state
    tick();
    rst = 1'b0;
    tick();

    // Up count through a full 256 cycle with wrap
    en = 1; up_dn = 1; tcs = 0;
    for (int i = 0; i < 256 * PSN; i++) begin
      tick();
      if (tc8) tcs++;
    end
    chk("wrap256.count", count8, 0);
    chk("wrap256.tc_pulses", tcs, 1);
    chk("wrap256.ovf", ovf8, 1);

    // Asynchronous reset mid-count at 37
    en = 0; load = 1; lv8 = 8'd37;
    tick();
    load = 0;
    chk("load37", count8, 37);
    #2;
    rst = 1'b1;
    #1;
    m8c = 0; m8t = 0; m8o = 0; m8ps = 0;
    m10c = 0; m10t = 0; m10o = 0; m10ps = 0;
    check_all();
    chk("async_rst.count", count8, 0);
    tick();
    rst = 1'b0;

    // Decade instance counting down, wrap from 0; ovf_clr colliding with a boundary event
    clear = 1; tick(); clear = 0;
    en = 1; up_dn = 0; sat_mode = 0;
    steps(1);
    chk("down.wrap_to_9", count10, 9);
    chk("down.tc", tc10, 1);
    steps(9);
    chk("down.at0", count10, 0);
    ovf_clr = 1;
    steps(1);
    ovf_clr = 0;
    chk("down.ovf_set_wins", ovf10, 1);
    en = 0; ovf_clr = 1; tick(); ovf_clr = 0;
    chk("ovf_clr.clears", ovf10, 0);

    // Saturate up from 8
    load = 1; lv8 = 8'd8; tick(); load = 0;
    en = 1; up_dn = 1; sat_mode = 1;
    for (int i = 0; i < 4; i++) begin
      steps(1);
      chk("sat.count", count10, 9);
      chk("sat.tc", tc10, 0);
    end
    chk("sat.ovf", ovf10, 1);

    // Clamped load, then clear beating load and en
    en = 0; sat_mode = 0; load = 1; lv8 = 8'd12;
    tick();
    chk("load_clamp", count10, 9);
    clear = 1; en = 1; ovf_clr = 1;
    tick();
    clear = 0; load = 0; ovf_clr = 0;
    chk("clr_prio.count", count10, 0);
    chk("clr_prio.ovf", ovf10, 0);

    // en toggled every other cycle, direction flipping
    for (int i = 0; i < 24; i++) begin
      en = (i % 2 == 0);
      up_dn = 1'($urandom);
      tick();
    end

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = 1'($urandom);
      sat_mode = ($urandom_range(0, 3) == 0);
      clear    = ($urandom_range(0, 39) == 0);
      load     = ($urandom_range(0, 24) == 0);
      ovf_clr  = ($urandom_range(0, 9) == 0);
      lv8      = 8'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
